aq_ifu_fetch_ctrl: RTL

AQ_IFU_FETCH_CTRL -- requirements
Module: aq_ifu_fetch_ctrl

---
 rtl/aq_ifu_fetch_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/aq_ifu_fetch_ctrl.sv
// IFU fetch controller: gates ICache fetch requests, tracks in-flight requests,
// marks stale responses after a cancel for dropping, and runs the low-power handshake.
module aq_ifu_fetch_ctrl #(
  parameter int OUTSTD_DEPTH = 2,
  parameter int MASK_NUM     = 2,
  localparam int CNT_W       = $clog2(OUTSTD_DEPTH + 1)
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic                ibuf_ctrl_inst_fetch,
  input  logic                icache_ctrl_inv_fsm_idle,
  input  logic                icache_ctrl_req_grant,
  input  logic                icache_ctrl_resp_vld,
  input  logic [MASK_NUM-1:0] ifu_mask_src,
  input  logic                cp0_ifu_lpmd_req,
  input  logic                rtu_ifu_flush_fe,
  input  logic                pcgen_ctrl_chgflw_vld,
  input  logic                pred_ctrl_stall,
  input  logic                icache_ctrl_stall,
  input  logic                idu_ifu_id_stall,
  output logic                ctrl_icache_req_vld,
  output logic                ctrl_icache_abort,
  output logic                ctrl_ipack_cancel,
  output logic                ctrl_btb_chgflw_vld,
  output logic                ctrl_ipack_resp_drop,
  output logic                ctrl_btb_stall,
  output logic                ctrl_ibuf_pop_en,
  output logic                ctrl_cp0_lpmd_ack,
  output logic [CNT_W-1:0]    ctrl_inflight_cnt
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUTSTD_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LPMD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] w_inflight_nxt;
  logic [CNT_W-1:0] r_stale;
  logic [CNT_W-1:0] w_stale_nxt;
  logic             w_cancel;
  logic             w_issue;
  logic             w_resp_dec;
  logic             w_drop;

  assign w_cancel = rtu_ifu_flush_fe | pcgen_ctrl_chgflw_vld;

  assign ctrl_icache_abort   = w_cancel;
  assign ctrl_ipack_cancel   = w_cancel;
  assign ctrl_btb_chgflw_vld = w_cancel;
  assign ctrl_btb_stall      = pred_ctrl_stall | icache_ctrl_stall;
  assign ctrl_ibuf_pop_en    = !idu_ifu_id_stall;

  assign ctrl_icache_req_vld = !cpurst && (r_state == RUN) && !cp0_ifu_lpmd_req
                               && ibuf_ctrl_inst_fetch && icache_ctrl_inv_fsm_idle
                               && !(|ifu_mask_src) && !w_cancel
                               && (r_inflight < DEPTH_C);

  assign w_issue    = ctrl_icache_req_vld & icache_ctrl_req_grant;
  // A response with nothing outstanding is ignored so the count cannot wrap.
  assign w_resp_dec = icache_ctrl_resp_vld & (r_inflight != '0);
  assign w_drop     = icache_ctrl_resp_vld & (r_stale != '0);

  assign ctrl_ipack_resp_drop = w_drop;
  assign ctrl_inflight_cnt    = r_inflight;
  assign ctrl_cp0_lpmd_ack    = (r_state == LPMD);

  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_issue, w_resp_dec})
      2'b10:   w_inflight_nxt = r_inflight + ONE_C;
      2'b01:   w_inflight_nxt = r_inflight - ONE_C;
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  // On cancel every request still outstanding after this cycle becomes stale.
  always_comb begin
    w_stale_nxt = r_stale;
    if (w_cancel) begin
      w_stale_nxt = w_inflight_nxt;
    end else if (w_drop) begin
      w_stale_nxt = r_stale - ONE_C;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (cp0_ifu_lpmd_req) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!cp0_ifu_lpmd_req)          w_state_nxt = RUN;
        else if (w_inflight_nxt == '0)  w_state_nxt = LPMD;
      end
      LPMD: begin
        if (!cp0_ifu_lpmd_req) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_state    <= RUN;
      r_inflight <= '0;
      r_stale    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_inflight_nxt;
      r_stale    <= w_stale_nxt;
    end
  end

  a_no_resp_underflow: assert property (
    @(posedge forever_cpuclk) disable iff (cpurst)
      !(icache_ctrl_resp_vld && (r_inflight == '0)))
    else $warning("icache response received with no request in flight");

endmodule
